// File: rtl/ham_pkg.sv
// Shared types for the 8/4 Hamming read-response path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ham_pkg;

    // Error-log state: nothing held, a correctable error held, an uncorrectable error held.
    typedef enum logic [1:0] {
        LOG_IDLE  = 2'd0,
        LOG_CORR  = 2'd1,
        LOG_FATAL = 2'd2
    } ham_log_e;

    // Beat as seen by the read-data consumer; poison marks uncorrectable data.
    typedef struct packed {
        logic [3:0] data;
        logic       poison;
    } ham_beat_t;

endpackage : ham_pkg

// File: rtl/ham_skid_buf.sv
// Two-entry skid buffer (main + skid register) on a valid/ready link.
// Latency: 1 cycle from input accept to out_vld; 1 beat/cycle while out_rdy stays high.
// Backpressure: in_rdy is flop-driven and drops only while the skid register is occupied.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   in_vld/in_rdy/in_dat    upstream handshake and payload
//   out_vld/out_rdy/out_dat downstream handshake and payload (held stable while stalled)
module ham_skid_buf #(
    parameter int unsigned W = 5
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    logic         main_vld_q;
    logic [W-1:0] main_dat_q;
    logic         skid_vld_q;
    logic [W-1:0] skid_dat_q;
    logic         acc;
    logic         pop;

    // in_rdy comes straight from state, so there is no path from out_rdy.
    assign in_rdy  = ~skid_vld_q;
    assign out_vld = main_vld_q;
    assign out_dat = main_dat_q;
    assign acc     = in_vld & in_rdy;
    assign pop     = main_vld_q & out_rdy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_vld_q <= 1'b0;
            main_dat_q <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else if (skid_vld_q) begin
            // Input is blocked; drain the older skid beat into main once main moves.
            if (pop) begin
                main_dat_q <= skid_dat_q;
                skid_vld_q <= 1'b0;
            end
        end else if (acc) begin
            if (!main_vld_q || pop) begin
                main_vld_q <= 1'b1;
                main_dat_q <= in_dat;
            end else begin
                // Main is stalled: park the new beat so in_rdy can stay registered.
                skid_vld_q <= 1'b1;
                skid_dat_q <= in_dat;
            end
        end else if (pop) begin
            main_vld_q <= 1'b0;
        end
    end

endmodule : ham_skid_buf

// File: rtl/ham_err_mon_8_4.sv
// Read-response stage after the 8/4 Hamming checker: forwards beats with poison, counts errors, logs first error, raises irq.
// Latency: 1 cycle accept->out_valid_o; counters, log and irq update on the accepting edge.
// Backpressure: 2-entry skid buffer, in_ready_o registered and low only while the skid slot is full.
//
// Ports: clk_i/rst_ni; in_* checked-beat input (valid/ready); out_* forwarded beat (valid/ready);
//        cnt_clr_i/cnt_corr_o/cnt_fatal_o saturating counters; log_clr_i/log_* first-error log; irq_o.
module ham_err_mon_8_4
    import ham_pkg::*;
#(
    parameter int unsigned AW          = 8,
    parameter int unsigned CW          = 8,
    parameter int unsigned CORR_THRESH = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [AW-1:0] in_addr_i,
    input  logic [3:0]    in_data_i,
    input  logic          in_error_i,
    input  logic          in_fatal_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [3:0]    out_data_o,
    output logic          out_poison_o,
    input  logic          cnt_clr_i,
    output logic [CW-1:0] cnt_corr_o,
    output logic [CW-1:0] cnt_fatal_o,
    input  logic          log_clr_i,
    output logic          log_valid_o,
    output logic          log_fatal_o,
    output logic [AW-1:0] log_addr_o,
    output logic          irq_o
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] THRESH  = CW'(CORR_THRESH);

    ham_beat_t     in_beat_dat;
    ham_beat_t     out_beat_dat;
    logic          acc;
    logic          ev_corr;
    logic          ev_fat;
    logic [CW-1:0] cnt_corr_q, cnt_corr_nxt;
    logic [CW-1:0] cnt_fatal_q, cnt_fatal_nxt;
    ham_log_e      log_q, log_cur, log_nxt;
    logic [AW-1:0] log_addr_q, log_addr_nxt;
    logic          irq_q;

    // ---------------- data path ----------------
    assign in_beat_dat = '{data: in_data_i, poison: in_fatal_i};

    ham_skid_buf #(.W($bits(ham_beat_t))) u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .in_vld  (in_valid_i),
        .in_rdy  (in_ready_o),
        .in_dat  (in_beat_dat),
        .out_vld (out_valid_o),
        .out_rdy (out_ready_i),
        .out_dat (out_beat_dat)
    );

    assign out_data_o   = out_beat_dat.data;
    assign out_poison_o = out_beat_dat.poison;

    // Flags only matter for beats actually taken; fatal wins even without error.
    assign acc     = in_valid_i & in_ready_o;
    assign ev_fat  = acc & in_fatal_i;
    assign ev_corr = acc & in_error_i & ~in_fatal_i;

    // ---------------- counters ----------------
    // Clear takes effect first, so a same-cycle event leaves the counter at 1.
    always_comb begin
        cnt_corr_nxt  = cnt_corr_q;
        cnt_fatal_nxt = cnt_fatal_q;
        if (cnt_clr_i) begin
            cnt_corr_nxt  = ev_corr ? CW'(1) : '0;
            cnt_fatal_nxt = ev_fat  ? CW'(1) : '0;
        end else begin
            if (ev_corr && cnt_corr_q != CNT_MAX) cnt_corr_nxt  = cnt_corr_q + 1'b1;
            if (ev_fat  && cnt_fatal_q != CNT_MAX) cnt_fatal_nxt = cnt_fatal_q + 1'b1;
        end
    end

    // ---------------- error log FSM ----------------
    always_comb begin
        // A clear behaves as if the log were already IDLE this cycle.
        log_cur      = log_clr_i ? LOG_IDLE : log_q;
        log_nxt      = log_cur;
        log_addr_nxt = log_addr_q;
        case (log_cur)
            LOG_IDLE: begin
                if (ev_fat) begin
                    log_nxt      = LOG_FATAL;
                    log_addr_nxt = in_addr_i;
                end else if (ev_corr) begin
                    log_nxt      = LOG_CORR;
                    log_addr_nxt = in_addr_i;
                end
            end
            LOG_CORR: begin
                if (ev_fat) begin
                    log_nxt      = LOG_FATAL;
                    log_addr_nxt = in_addr_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_corr_q  <= '0;
            cnt_fatal_q <= '0;
            log_q       <= LOG_IDLE;
            log_addr_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            cnt_corr_q  <= cnt_corr_nxt;
            cnt_fatal_q <= cnt_fatal_nxt;
            log_q       <= log_nxt;
            log_addr_q  <= log_addr_nxt;
            // Computed from next-state values so irq tracks the state it will describe.
            irq_q       <= (log_nxt == LOG_FATAL) || (cnt_corr_nxt >= THRESH);
        end
    end

    assign cnt_corr_o  = cnt_corr_q;
    assign cnt_fatal_o = cnt_fatal_q;
    assign log_valid_o = (log_q != LOG_IDLE);
    assign log_fatal_o = (log_q == LOG_FATAL);
    assign log_addr_o  = log_addr_q;
    assign irq_o       = irq_q;

endmodule : ham_err_mon_8_4
